// File: rtl/rob_wb_arbiter_if.sv
// Shared configuration package and the ROB writeback lane interface.
// `parameters` fixes the lane count and the field widths; `robWbIf`
// carries one registered writeback per lane toward the ROB.

package parameters;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int DISPATCH_ADDR_WIDTH  = 1;
  localparam int ROB_ADDR_WIDTH       = 5;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
endpackage

interface robWbIf;
  import parameters::*;

  logic [DISPATCH_WIDTH-1:0]                          en;
  logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
  logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       rob_addr;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
  logic [DISPATCH_WIDTH-1:0]                          is_branch;
  logic [DISPATCH_WIDTH-1:0]                          taken;

  modport out (output en, bank_addr, rob_addr, phys_rd, is_branch, taken);
  modport in  (input  en, bank_addr, rob_addr, phys_rd, is_branch, taken);
endinterface

// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: buffers completions from NUM_FU functional units in small
// per-FU FIFOs and grants up to DISPATCH_WIDTH heads per cycle onto the ROB
// writeback lanes, scanning round-robin from rr_ptr. Lane outputs are
// registered; a flush discards everything pending.
// Optional build macro ROB_WB_ARB_BYPASS_EN: an FU with an empty FIFO and a
// valid completion competes in the same cycle and, if granted, skips its FIFO.

module rob_wb_arbiter
  import parameters::*;
#(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           flush,
  input  logic [NUM_FU-1:0]                              fu_valid,
  output logic [NUM_FU-1:0]                              fu_ready,
  input  logic [NUM_FU-1:0][DISPATCH_ADDR_WIDTH-1:0]     fu_bank_addr,
  input  logic [NUM_FU-1:0][ROB_ADDR_WIDTH-1:0]          fu_rob_addr,
  input  logic [NUM_FU-1:0][PHYS_REGS_ADDR_WIDTH-1:0]    fu_phys_rd,
  input  logic [NUM_FU-1:0]                              fu_is_branch,
  input  logic [NUM_FU-1:0]                              fu_taken,
  robWbIf.out                                            wb
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int DW    = DISPATCH_WIDTH;

  typedef struct packed {
    logic [DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic                            is_branch;
    logic                            taken;
  } wb_pl_t;

  wb_pl_t            mem     [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr  [NUM_FU];
  logic [PTR_W-1:0]  wr_ptr  [NUM_FU];
  logic [CNT_W-1:0]  count   [NUM_FU];
  logic [FU_W-1:0]   rr_ptr;
  logic [FU_W-1:0]   rr_nxt;

  wb_pl_t            fu_pl   [NUM_FU];
  wb_pl_t            head_pl [NUM_FU];
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] cand;
  logic [NUM_FU-1:0] rot;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] wr_en;

  logic [DW-1:0]     lane_vld;
  logic [FU_W-1:0]   lane_sel [DW];
  wb_pl_t            lane_pl  [DW];

  logic [DW-1:0]     en_q;
  wb_pl_t            lane_q   [DW];

  // Per-FU payload packing, acceptance and candidate selection.
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_pl[i]    = '{bank_addr: fu_bank_addr[i], rob_addr: fu_rob_addr[i],
                      phys_rd: fu_phys_rd[i], is_branch: fu_is_branch[i],
                      taken: fu_taken[i]};
      fu_ready[i] = count[i] < CNT_W'(FIFO_DEPTH);
      push[i]     = fu_valid[i] & fu_ready[i] & ~flush;
`ifdef ROB_WB_ARB_BYPASS_EN
      cand[i]     = (count[i] != '0) | push[i];
      head_pl[i]  = (count[i] == '0) ? fu_pl[i] : mem[i][rd_ptr[i]];
`else
      cand[i]     = count[i] != '0;
      head_pl[i]  = mem[i][rd_ptr[i]];
`endif
    end
  end

  // Round-robin grant: rotate candidates so scan position k is FU
  // (rr_ptr + k) mod NUM_FU, then hand the first DW hits to lanes in order.
  always_comb begin
    int unsigned hits;
    rot      = NUM_FU'({cand, cand} >> rr_ptr);
    lane_vld = '0;
    hits     = 0;
    for (int unsigned l = 0; l < DW; l++) begin
      lane_sel[l] = '0;
      lane_pl[l]  = '0;
    end
    if (!flush) begin
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        if (rot[k] && hits < DW) begin
          for (int unsigned l = 0; l < DW; l++) begin
            if (hits == l) begin
              lane_vld[l] = 1'b1;
              lane_sel[l] = FU_W'((32'(rr_ptr) + k) % NUM_FU);
            end
          end
          hits++;
        end
      end
    end
    grant  = '0;
    rr_nxt = rr_ptr;
    for (int unsigned l = 0; l < DW; l++) begin
      if (lane_vld[l]) begin
        lane_pl[l] = head_pl[lane_sel[l]];
        rr_nxt     = (lane_sel[l] == FU_W'(NUM_FU - 1)) ? '0 : lane_sel[l] + 1'b1;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
          if (lane_sel[l] == FU_W'(i)) grant[i] = 1'b1;
        end
      end
    end
    // A grant on an empty FIFO can only be a bypass: no pop, no write.
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      pop[i]   = grant[i] & (count[i] != '0);
      wr_en[i] = push[i] & ~(grant[i] & (count[i] == '0));
    end
  end

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
      end
      rr_ptr <= rr_nxt;
    end
  end

  // FIFO storage; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= fu_pl[i];
    end
  end

  // Lane registers: granted lanes load payload, others clear (flush yields no grants).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int unsigned l = 0; l < DW; l++) lane_q[l] <= '0;
    end else begin
      for (int unsigned l = 0; l < DW; l++) begin
        en_q[l]   <= lane_vld[l];
        lane_q[l] <= lane_vld[l] ? lane_pl[l] : '0;
      end
    end
  end

  assign wb.en = en_q;
  for (genvar l = 0; l < DW; l++) begin : g_lane
    assign wb.bank_addr[l] = lane_q[l].bank_addr;
    assign wb.rob_addr[l]  = lane_q[l].rob_addr;
    assign wb.phys_rd[l]   = lane_q[l].phys_rd;
    assign wb.is_branch[l] = lane_q[l].is_branch;
    assign wb.taken[l]     = lane_q[l].taken;
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter (NUM_FU=4, FIFO_DEPTH=2, two lanes, no bypass):
// directed vectors with hand-computed expectations plus a per-cycle
// reference of the per-FU queues and round-robin lane assignment.

module tb_rob_wb_arbiter;
  import parameters::*;

  localparam int NF = 4;
  localparam int FD = 2;
  localparam int DW = DISPATCH_WIDTH;

  logic                                        clk;
  logic                                        rst_n;
  logic                                        flush;
  logic [NF-1:0]                               fu_valid;
  logic [NF-1:0]                               fu_ready;
  logic [NF-1:0][DISPATCH_ADDR_WIDTH-1:0]      fu_bank_addr;
  logic [NF-1:0][ROB_ADDR_WIDTH-1:0]           fu_rob_addr;
  logic [NF-1:0][PHYS_REGS_ADDR_WIDTH-1:0]     fu_phys_rd;
  logic [NF-1:0]                               fu_is_branch;
  logic [NF-1:0]                               fu_taken;

  robWbIf wb_if ();

  rob_wb_arbiter #(.NUM_FU(NF), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fu_valid     (fu_valid),
    .fu_ready     (fu_ready),
    .fu_bank_addr (fu_bank_addr),
    .fu_rob_addr  (fu_rob_addr),
    .fu_phys_rd   (fu_phys_rd),
    .fu_is_branch (fu_is_branch),
    .fu_taken     (fu_taken),
    .wb           (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: queued payloads per FU, pointer, and pushes seen this edge.
  logic [31:0]   q [NF][$];
  int unsigned   rr_m;
  logic [NF-1:0] pend_v;
  logic [31:0]   pend_d [NF];
  logic          flush_s;
  int            pushes;
  int            wbs;

  function automatic logic [31:0] fu_pack(input int f);
    return 32'({fu_bank_addr[f], fu_rob_addr[f], fu_phys_rd[f], fu_is_branch[f], fu_taken[f]});
  endfunction

  function automatic logic [31:0] lane_pack(input int l);
    return 32'({wb_if.bank_addr[l], wb_if.rob_addr[l], wb_if.phys_rd[l],
                wb_if.is_branch[l], wb_if.taken[l]});
  endfunction

  function automatic int q_total();
    int t = 0;
    for (int f = 0; f < NF; f++) t += q[f].size();
    return t;
  endfunction

  task automatic sb_clear();
    for (int f = 0; f < NF; f++) q[f].delete();
    rr_m   = 0;
    pushes = 0;
    wbs    = 0;
  endtask

  task automatic sb_update();
    logic [DW-1:0] exp_en;
    logic [31:0]   exp_d [DW];
    int unsigned   n;
    int unsigned   base;
    int unsigned   f;
    exp_en = '0;
    n      = 0;
    base   = rr_m;
    for (int l = 0; l < DW; l++) exp_d[l] = '0;
    if (flush_s) begin
      for (int i = 0; i < NF; i++) q[i].delete();
      rr_m = 0;
    end else begin
      for (int unsigned k = 0; k < NF; k++) begin
        f = (base + k) % NF;
        if (q[f].size() > 0 && n < DW) begin
          exp_d[n]  = q[f].pop_front();
          exp_en[n] = 1'b1;
          rr_m      = (f + 1) % NF;
          n++;
        end
      end
    end
    check("lane_en", 32'(wb_if.en), 32'(exp_en));
    for (int l = 0; l < DW; l++) check("lane_data", lane_pack(l), exp_d[l]);
    wbs += int'(n);
    if (!flush_s) begin
      for (int i = 0; i < NF; i++) begin
        if (pend_v[i]) begin
          q[i].push_back(pend_d[i]);
          pushes++;
        end
      end
    end
  endtask

  // One clock: note what the DUT accepts at this edge, then sample 1ns after.
  task automatic tick();
    flush_s = flush;
    for (int f = 0; f < NF; f++) begin
      pend_v[f] = rst_n && !flush && fu_valid[f] && fu_ready[f];
      pend_d[f] = fu_pack(f);
    end
    @(posedge clk);
    #1;
    if (rst_n) sb_update();
  endtask

  task automatic idle();
    flush        = 1'b0;
    fu_valid     = '0;
    fu_bank_addr = '0;
    fu_rob_addr  = '0;
    fu_phys_rd   = '0;
    fu_is_branch = '0;
    fu_taken     = '0;
  endtask

  task automatic drv(input int f, input int rob, input int phys, input bit br, input bit tk, input bit bank);
    fu_valid[f]     = 1'b1;
    fu_rob_addr[f]  = ROB_ADDR_WIDTH'(rob);
    fu_phys_rd[f]   = PHYS_REGS_ADDR_WIDTH'(phys);
    fu_is_branch[f] = br;
    fu_taken[f]     = tk;
    fu_bank_addr[f] = DISPATCH_ADDR_WIDTH'(bank);
  endtask

  int seq [NF];
  int sent2;

  initial begin
    rst_n = 1'b0;
    idle();
    sb_clear();
    repeat (3) tick();

    // Reset state
    check("rst_ready", 32'(fu_ready), 32'hF);
    check("rst_en", 32'(wb_if.en), 32'h0);
    check("rst_rob0", 32'(wb_if.rob_addr[0]), 32'h0);
    rst_n = 1'b1;

    // Single push from FU1: latency 2, lane0 only, one-cycle pulse
    drv(1, 5, 12, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    check("t1_ready", 32'(fu_ready), 32'hF);
    check("t1_early_en", 32'(wb_if.en), 32'h0);
    tick();
    check("t1_en", 32'(wb_if.en), 32'h1);
    check("t1_rob", 32'(wb_if.rob_addr[0]), 32'd5);
    check("t1_phys", 32'(wb_if.phys_rd[0]), 32'd12);
    check("t1_br", 32'(wb_if.is_branch[0]), 32'd1);
    check("t1_tk", 32'(wb_if.taken[0]), 32'd1);
    check("t1_bank", 32'(wb_if.bank_addr[0]), 32'd1);
    tick();
    check("t1_pulse", 32'(wb_if.en), 32'h0);

    // Contention: flush returns the pointer to 0, then all four push at once
    flush = 1'b1;
    tick();
    idle();
    for (int f = 0; f < NF; f++) drv(f, 10 + f, 20 + f, 1'b0, 1'b0, f[0]);
    tick();
    idle();
    tick();
    check("ct_a_en", 32'(wb_if.en), 32'h3);
    check("ct_a_l0", 32'(wb_if.rob_addr[0]), 32'd10);
    check("ct_a_l1", 32'(wb_if.rob_addr[1]), 32'd11);
    tick();
    check("ct_b_en", 32'(wb_if.en), 32'h3);
    check("ct_b_l0", 32'(wb_if.rob_addr[0]), 32'd12);
    check("ct_b_l1", 32'(wb_if.rob_addr[1]), 32'd13);
    // pointer back at 0: FU0 must lead FU3
    drv(0, 20, 1, 1'b0, 1'b0, 1'b0);
    drv(3, 23, 2, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    check("ct_rr_l0", 32'(wb_if.rob_addr[0]), 32'd20);
    check("ct_rr_l1", 32'(wb_if.rob_addr[1]), 32'd23);
    tick();

    // Backpressure: FU2 offers three back-to-back while the others stay busy
    for (int f = 0; f < NF; f++) seq[f] = 0;
    sent2 = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      for (int f = 0; f < NF; f++) begin
        if ((f != 2 && c < 8) || (f == 2 && sent2 < 3))
          drv(f, f * 8 + (seq[f] % 8), 40 + f, f[0], f[1], 1'b0);
      end
      tick();
      for (int f = 0; f < NF; f++) if (pend_v[f]) seq[f]++;
      if (pend_v[2]) sent2++;
      if (c == 1) check("bp_ready2_lo", 32'(fu_ready[2]), 32'd0);
      if (c == 2) check("bp_ready2_hi", 32'(fu_ready[2]), 32'd1);
    end
    idle();
    repeat (8) tick();
    check("bp_sent2", 32'(sent2), 32'd3);
    check("bp_drain", 32'(q_total()), 32'd0);
    check("bp_push_wb", 32'(wbs), 32'(pushes));

    // Flush with three pending entries while FU0 pushes
    drv(1, 7, 3, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (2) tick();
    drv(1, 1, 11, 1'b0, 1'b0, 1'b0);
    drv(2, 2, 12, 1'b0, 1'b0, 1'b0);
    drv(3, 3, 13, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    flush = 1'b1;
    drv(0, 9, 19, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    check("fl_en", 32'(wb_if.en), 32'h0);
    check("fl_ready", 32'(fu_ready), 32'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fl_quiet", 32'(wb_if.en), 32'h0);
    end
    drv(0, 20, 1, 1'b0, 1'b0, 1'b0);
    drv(3, 23, 2, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check("fl_rr_l0", 32'(wb_if.rob_addr[0]), 32'd20);
    check("fl_rr_l1", 32'(wb_if.rob_addr[1]), 32'd23);
    tick();

    // Asynchronous reset between edges with entries queued
    for (int f = 0; f < NF; f++) drv(f, 16 + f, 30 + f, 1'b0, 1'b0, 1'b0);
    tick();
    for (int f = 0; f < NF; f++) drv(f, 24 + f, 50 + f, 1'b0, 1'b0, 1'b0);
    tick();
    check("ar_pre_en", 32'(wb_if.en), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_en", 32'(wb_if.en), 32'h0);
    check("ar_ready", 32'(fu_ready), 32'hF);
    check("ar_rob0", 32'(wb_if.rob_addr[0]), 32'h0);
    sb_clear();
    repeat (2) tick();
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("ar_stale", 32'(wb_if.en), 32'h0);
    end

    // Soak: random traffic on all FUs against the reference
    for (int c = 0; c < 10000; c++) begin
      for (int f = 0; f < NF; f++) begin
        fu_valid[f]     = 1'($urandom_range(0, 1));
        fu_rob_addr[f]  = ROB_ADDR_WIDTH'($urandom);
        fu_phys_rd[f]   = PHYS_REGS_ADDR_WIDTH'($urandom);
        fu_is_branch[f] = 1'($urandom);
        fu_taken[f]     = 1'($urandom);
        fu_bank_addr[f] = DISPATCH_ADDR_WIDTH'($urandom);
      end
      tick();
    end
    idle();
    repeat (8) tick();
    check("soak_drain", 32'(q_total()), 32'd0);
    check("soak_push_wb", 32'(wbs), 32'(pushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
